// File: rtl/router_pkg.sv
// Shared constants and helpers for the router output buffer.
package router_pkg;

    // Default buffer geometry
    localparam int unsigned DEF_WIDTH   = 8;
    localparam int unsigned DEF_DEPTH   = 16;

    // Header tag sits just above the data byte in each stored word
    localparam int unsigned HDR_TAG_BIT = DEF_WIDTH;

    // Payload length field inside a header byte
    localparam int unsigned LEN_MSB     = 7;
    localparam int unsigned LEN_LSB     = 2;

    localparam int unsigned PKT_CNT_W   = 6;

    // Bytes still to come after a header: payload length plus parity, saturated.
    function automatic logic [PKT_CNT_W-1:0] hdr_pkt_cnt(input logic [LEN_MSB:0] hdr);
        logic [PKT_CNT_W:0] len_p1;
        len_p1 = {1'b0, hdr[LEN_MSB:LEN_LSB]} + (PKT_CNT_W+1)'(1);
        return len_p1[PKT_CNT_W] ? {PKT_CNT_W{1'b1}} : len_p1[PKT_CNT_W-1:0];
    endfunction

endpackage

// File: rtl/router_fifo_mem.sv
// Simple dual-port register array: synchronous write, combinational read.
module router_fifo_mem #(
    parameter int unsigned W     = 9,
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [W-1:0]  wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [W-1:0]  rdata_o
);

    logic [W-1:0] mem_q [DEPTH];

    // Storage is never reset; occupancy is tracked by the controller.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/router_fifo.sv
// Per-destination output buffer for the 1x3 router.
// Stores {header tag, byte}; the read side counts down the bytes of the packet in flight.
// Optional build macro ROUTER_FIFO_ERR_EN adds the sticky ovf_err_o flag.
module router_fifo
    import router_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned DEPTH = DEF_DEPTH,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             soft_reset_i,
    input  logic             write_enb_i,
    input  logic             lfd_state_i,
    input  logic [WIDTH-1:0] data_in_i,
    input  logic             read_enb_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o,
    output logic             pkt_busy_o
`ifdef ROUTER_FIFO_ERR_EN
    ,
    output logic             ovf_err_o
`endif
);

    logic [AW:0]            wr_ptr_q, wr_ptr_d;
    logic [AW:0]            rd_ptr_q, rd_ptr_d;
    logic [AW:0]            count_q, count_d;
    logic [PKT_CNT_W-1:0]   pkt_cnt_q, pkt_cnt_d;
    logic [WIDTH-1:0]       dout_q, dout_d;

    logic                   wr_acc, rd_acc;
    logic                   mem_we;
    logic [WIDTH:0]         rd_word;

    assign full_o     = (count_q == (AW+1)'(DEPTH));
    assign empty_o    = (count_q == '0);
    assign pkt_busy_o = (pkt_cnt_q != '0);
    assign dout_o     = dout_q;

    assign wr_acc = write_enb_i && !full_o;
    assign rd_acc = read_enb_i && !empty_o;
    // A flushing cycle must not leave a stale word behind.
    assign mem_we = wr_acc && !soft_reset_i;

    router_fifo_mem #(
        .W     (WIDTH + 1),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk_i   (clk_i),
        .we_i    (mem_we),
        .waddr_i (wr_ptr_q[AW-1:0]),
        .wdata_i ({lfd_state_i, data_in_i}),
        .raddr_i (rd_ptr_q[AW-1:0]),
        .rdata_o (rd_word)
    );

    // Next-state for pointers, occupancy, packet counter and read data.
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        pkt_cnt_d = pkt_cnt_q;
        dout_d    = dout_q;

        if (soft_reset_i) begin
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            count_d   = '0;
            pkt_cnt_d = '0;
            dout_d    = '0;
        end else begin
            if (wr_acc) begin
                wr_ptr_d = wr_ptr_q + (AW+1)'(1);
            end
            if (rd_acc) begin
                rd_ptr_d = rd_ptr_q + (AW+1)'(1);
                dout_d   = rd_word[WIDTH-1:0];
                if (rd_word[WIDTH]) begin
                    pkt_cnt_d = hdr_pkt_cnt(rd_word[LEN_MSB:0]);
                end else if (pkt_cnt_q != '0) begin
                    pkt_cnt_d = pkt_cnt_q - PKT_CNT_W'(1);
                end
            end
            unique case ({wr_acc, rd_acc})
                2'b10:   count_d = count_q + (AW+1)'(1);
                2'b01:   count_d = count_q - (AW+1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            pkt_cnt_q <= '0;
            dout_q    <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            pkt_cnt_q <= pkt_cnt_d;
            dout_q    <= dout_d;
        end
    end

`ifdef ROUTER_FIFO_ERR_EN
    logic ovf_err_q, ovf_err_d;

    // Sticky flag for any rejected access; only a reset or flush clears it.
    always_comb begin
        ovf_err_d = ovf_err_q;
        if (soft_reset_i) begin
            ovf_err_d = 1'b0;
        end else if ((write_enb_i && full_o) || (read_enb_i && empty_o)) begin
            ovf_err_d = 1'b1;
        end
    end

    // Error flag register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ovf_err_q <= 1'b0;
        end else begin
            ovf_err_q <= ovf_err_d;
        end
    end

    assign ovf_err_o = ovf_err_q;
`endif

endmodule

// File: tb/tb_router_fifo.sv
// Self-checking bench for router_fifo against a queue-based reference model.
// Build with +define+ROUTER_FIFO_ERR_EN to also check ovf_err_o.
module tb_router_fifo;

    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       soft_reset = 1'b0;
    logic       write_enb = 1'b0;
    logic       lfd_state = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       read_enb = 1'b0;
    logic [7:0] dout;
    logic       full, empty, pkt_busy;
`ifdef ROUTER_FIFO_ERR_EN
    logic       ovf_err;
`endif

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    logic [8:0] m_q[$];
    logic [7:0] m_dout = 8'h00;
    int         m_pkt = 0;
    bit         m_ovf = 1'b0;

    router_fifo dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .soft_reset_i (soft_reset),
        .write_enb_i  (write_enb),
        .lfd_state_i  (lfd_state),
        .data_in_i    (data_in),
        .read_enb_i   (read_enb),
        .dout_o       (dout),
        .full_o       (full),
        .empty_o      (empty),
        .pkt_busy_o   (pkt_busy)
`ifdef ROUTER_FIFO_ERR_EN
        ,
        .ovf_err_o    (ovf_err)
`endif
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    // One clock cycle: drive inputs, advance the model, compare outputs after the edge.
    task automatic step(input bit r, input bit s, input bit we, input bit lfd,
                        input logic [7:0] din, input bit re);
        bit         m_full, m_empty, do_wr, do_rd;
        logic [8:0] w;
        int         len;
        @(negedge clk);
        rst = r; soft_reset = s; write_enb = we; lfd_state = lfd; data_in = din; read_enb = re;

        if (r || s) begin
            m_q.delete();
            m_dout = 8'h00;
            m_pkt  = 0;
            m_ovf  = 1'b0;
        end else begin
            m_full  = (m_q.size() == DEPTH);
            m_empty = (m_q.size() == 0);
            if ((we && m_full) || (re && m_empty)) m_ovf = 1'b1;
            do_wr = we && !m_full;
            do_rd = re && !m_empty;
            if (do_rd) begin
                w = m_q.pop_front();
                m_dout = w[7:0];
                if (w[8]) begin
                    len = int'(w[7:2]) + 1;
                    m_pkt = (len > 63) ? 63 : len;
                end else if (m_pkt > 0) begin
                    m_pkt = m_pkt - 1;
                end
            end
            if (do_wr) m_q.push_back({lfd, din});
        end

        @(posedge clk);
        #1;
        check_val("empty", 32'(empty), 32'(m_q.size() == 0));
        check_val("full", 32'(full), 32'(m_q.size() == DEPTH));
        check_val("pkt_busy", 32'(pkt_busy), 32'(m_pkt != 0));
        check_val("dout", 32'(dout), 32'(m_dout));
`ifdef ROUTER_FIFO_ERR_EN
        check_val("ovf_err", 32'(ovf_err), 32'(m_ovf));
`endif
    endtask

    task automatic wr(input bit lfd, input logic [7:0] din);
        step(0, 0, 1, lfd, din, 0);
    endtask

    task automatic rd();
        step(0, 0, 0, 0, 8'h00, 1);
    endtask

    task automatic write_pkt5();
        wr(1, 8'h0D);
        wr(0, 8'hAA);
        wr(0, 8'hBB);
        wr(0, 8'hCC);
        wr(0, 8'hDA);
    endtask

    initial begin
        // Reset and idle
        step(1, 0, 0, 0, 8'h00, 0);
        step(1, 0, 0, 0, 8'h00, 0);
        step(0, 0, 0, 0, 8'h00, 0);

        // Packet pass-through
        write_pkt5();
        for (int i = 0; i < 5; i++) rd();
        check_val("pkt_drained", 32'(pkt_busy), 32'(0));

        // Fill and overflow, then drain and underflow
        for (int i = 1; i <= 17; i++) wr(0, 8'(i));
        for (int i = 0; i < 17; i++) rd();
        step(0, 1, 0, 0, 8'h00, 0);

        // Simultaneous access at full, then at empty
        for (int i = 0; i < DEPTH; i++) wr(0, 8'(8'h20 + i));
        step(0, 0, 1, 0, 8'h55, 1);
        for (int i = 0; i < DEPTH - 1; i++) rd();
        step(0, 0, 1, 0, 8'h77, 1);
        rd();

        // Wrap-around
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 10; i++) wr(0, 8'(k * 16 + i + 8'h40));
            for (int i = 0; i < 10; i++) rd();
        end

        // Soft reset mid-packet, concurrent write discarded
        write_pkt5();
        rd();
        rd();
        step(0, 1, 1, 1, 8'h99, 0);
        rd();

        // Length field 63 saturates the packet counter
        step(0, 1, 0, 0, 8'h00, 0);
        wr(1, 8'hFF);
        for (int i = 0; i < 70; i++) step(0, 0, 1, 0, 8'(i), 1);
        step(0, 1, 0, 0, 8'h00, 0);

        // Randomized traffic with occasional flushes and resets
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 399) == 0), ($urandom_range(0, 99) == 0),
                 ($urandom_range(0, 99) < 55), ($urandom_range(0, 7) == 0),
                 8'($urandom), ($urandom_range(0, 99) < 50));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/router_fifo.md
Name: router_fifo

Overview:
Per-destination output buffer for the 1x3 router. Sits directly downstream of the register stage and stores its byte stream (header, payload, parity). Tags each header byte with the lfd_state marker so the read side can track packet boundaries. Three instances, one per output port, are drained by the destination read enables.

Parameters:
WIDTH, 8, data byte width
DEPTH, 16, number of storage words (power of two)
AW, 4, address width = log2(DEPTH)

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
soft_reset  input  1  synchronous flush from the synchroniser (read-timeout)
write_enb  input  1  write request for this port
lfd_state  input  1  current data_in is a header byte; stored as tag bit
data_in  input  WIDTH  byte from register stage dout
read_enb  input  1  read request from destination
dout  output  WIDTH  registered read data
full  output  1  count == DEPTH
empty  output  1  count == 0
pkt_busy  output  1  read side is inside a packet (pkt_cnt != 0)

Behaviour:
- Storage: DEPTH words of WIDTH+1 bits; bit WIDTH = header tag (lfd_state at write).
- Pointers: wr_ptr and rd_ptr are AW+1 bits and wrap modulo 2*DEPTH. Index = low AW bits. count is an AW+1-bit occupancy register.
- Write accepted iff write_enb && !full (current-cycle full). Stores {lfd_state, data_in} at wr_ptr; wr_ptr++.
- Read accepted iff read_enb && !empty. dout <= mem[rd_ptr][WIDTH-1:0] at the next edge (1-cycle latency); rd_ptr++.
- No accepted read: dout holds its last value.
- Simultaneous read and write:
  - Both accepted: count unchanged.
  - When full: read accepted, write dropped (no overwrite); full deasserts next cycle.
  - When empty: write accepted, read ignored (no bypass); dout unchanged.
- Rejected writes and rejected reads change no state.
- Packet counter pkt_cnt (6 bits):
  - On an accepted read of a tagged word: pkt_cnt <= data[7:2] + 1 (payload length + parity byte).
  - On an accepted read of an untagged word with pkt_cnt != 0: pkt_cnt--.
  - Untagged read with pkt_cnt == 0: pkt_cnt stays 0 and the data is still delivered.
  - Length field 63: +1 is computed at 7 bits and saturates to 63.
- full, empty and pkt_busy are combinational from registered state.
- rst (highest priority): wr_ptr, rd_ptr, count, pkt_cnt and dout go to 0. Resulting outputs: full=0, empty=1, pkt_busy=0, dout=0. Memory contents are don't-care.
- soft_reset (below rst, above all operations): same clearing as rst. Writes and reads in the same cycle are discarded. Applies mid-packet with no residual state.

Optional Feature:
ROUTER_FIFO_ERR_EN:
- Defined: adds output ovf_err (1 bit, sticky). Set on the cycle after write_enb && full, or read_enb && empty. Cleared only by rst or soft_reset.
- Undefined: port and logic absent; rejected accesses are silent. All other behaviour is identical.

Decomposition:
- router_pkg holds:
  - HDR_TAG_BIT index (= WIDTH)
  - LEN_MSB=7, LEN_LSB=2 (length field in header)
  - PKT_CNT_W=6
  - default WIDTH and DEPTH constants
- Sub-module router_fifo_mem: simple dual-port register array with synchronous write, combinational read, parameterised by WIDTH+1 and DEPTH.
- Pointer, count, packet-counter logic and flags stay in router_fifo.

Test Plan:
- Reset/idle: rst for 2 cycles, then idle → empty=1, full=0, pkt_busy=0, dout=0.
- Packet pass-through: write header 8'h0D (len 3) with lfd_state=1, then 8'hAA, 8'hBB, 8'hCC, parity 8'hDA; read 5 times → dout sequence 0D, AA, BB, CC, DA, each one cycle after its read. pkt_cnt after each read: 4, 3, 2, 1, 0. pkt_busy drops after the parity read.
- Fill/overflow: 17 consecutive writes of 8'h01..8'h11 → full=1 after the 16th. Word 8'h11 is dropped. Reading 16 words returns 01..10, then empty=1. With ROUTER_FIFO_ERR_EN, ovf_err=1 after the 17th write.
- Simultaneous access: at full, assert write_enb and read_enb together → read returns oldest word, write dropped, count=15. At empty, the same → count=1, dout unchanged.
- Wrap-around: 3 cycles of write 10 / read 10 (30 words) → data order preserved across pointer wrap; count returns to 0.
- Soft reset mid-packet: after reading 2 of 5 bytes, pulse soft_reset together with write_enb → count=0, empty=1, pkt_busy=0, dout=0; the concurrent write is not stored.
